// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU stage, the result FIFO and its consumer.
// The slave modport is the FIFO view; master is the producer/consumer view.
interface alu_result_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic        in_cout;
  logic        in_overflow;
  logic [3:0]  in_op;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_cout;
  logic        out_overflow;
  logic [3:0]  out_op;

  modport slave (
    input  in_valid, in_result, in_zero, in_cout, in_overflow, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_cout, out_overflow, out_op
  );

  modport master (
    output in_valid, in_result, in_zero, in_cout, in_overflow, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_cout, out_overflow, out_op
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Circular-buffer FIFO holding ALU results with their flags and opcode,
// plus a sticky overflow flag and a saturating overflow counter.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_fifo_if.slave         bus,
  input  logic                     clr_status,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
  output logic [7:0]               ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 39;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_en_q, ready_en_d;
  logic          sticky_q, sticky_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;

  logic          in_ready_int;
  logic          out_valid_int;
  logic          push;
  logic          pop;
  logic [EW-1:0] in_entry;
  logic [EW-1:0] head;

  // ready_en_q keeps in_ready low until the first edge after reset releases
  always_comb begin
    in_ready_int  = ready_en_q && (count_q != FULL_CNT);
    out_valid_int = (count_q != '0);
    push          = bus.in_valid && in_ready_int;
    pop           = out_valid_int && bus.out_ready;
    in_entry      = {bus.in_op, bus.in_overflow, bus.in_cout, bus.in_zero, bus.in_result};

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_en_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // clear first so a same-edge overflow push still counts as the first
    sticky_d  = clr_status ? 1'b0 : sticky_q;
    ovf_cnt_d = clr_status ? 8'd0 : ovf_cnt_q;
    if (push && bus.in_overflow) begin
      sticky_d = 1'b1;
      if (ovf_cnt_d != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      sticky_q   <= 1'b0;
      ovf_cnt_q  <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
      sticky_q   <= sticky_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  always_comb begin
    head             = mem_q[rd_ptr_q];
    bus.in_ready     = in_ready_int;
    bus.out_valid    = out_valid_int;
    bus.out_result   = head[31:0];
    bus.out_zero     = head[32];
    bus.out_cout     = head[33];
    bus.out_overflow = head[34];
    bus.out_op       = head[38:35];
    count            = count_q;
    sticky_ovf       = sticky_q;
    ovf_cnt          = ovf_cnt_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: ordering, full/empty edges,
// overflow statistics and asynchronous reset.
module tb_alu_result_fifo;

  logic       clk;
  logic       rst;
  logic       clr_status;
  logic [2:0] count;
  logic       sticky_ovf;
  logic [7:0] ovf_cnt;

  int compared;
  int mismatched;

  alu_result_fifo_if bus ();

  alu_result_fifo #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .clr_status (clr_status),
    .count      (count),
    .sticky_ovf (sticky_ovf),
    .ovf_cnt    (ovf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [3:0] op,
                               input logic z, input logic c, input logic o,
                               input logic rdy, input logic clr);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_op       = op;
    bus.in_zero     = z;
    bus.in_cout     = c;
    bus.in_overflow = o;
    bus.out_ready   = rdy;
    clr_status      = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    clr_status = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_result   = 32'd0;
    bus.in_op       = 4'd0;
    bus.in_zero     = 1'b0;
    bus.in_cout     = 1'b0;
    bus.in_overflow = 1'b0;
    bus.out_ready   = 1'b0;

    #3;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("rst_out_result", bus.out_result, 32'd0);

    // Offer data across the release edge: it must be refused
    #8;
    rst = 1'b0;
    applyStimulus(1'b1, 32'd99, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("release_count", 32'(count), 32'd0);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Single push into empty FIFO
    applyStimulus(1'b1, 32'h0000_0005, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("single_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_out_result", bus.out_result, 32'd5);
    checkOutput("single_out_op", 32'(bus.out_op), 32'd2);
    checkOutput("single_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("single_drain_count", 32'(count), 32'd0);

    // Pop on empty is ignored; flags pass through untouched
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("empty_pop_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("flags_result", bus.out_result, 32'hDEAD_BEEF);
    checkOutput("flags_zero", 32'(bus.out_zero), 32'd1);
    checkOutput("flags_cout", 32'(bus.out_cout), 32'd1);
    checkOutput("flags_ovf", 32'(bus.out_overflow), 32'd0);
    checkOutput("flags_op", 32'(bus.out_op), 32'hA);
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fill to full, fifth push dropped
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 32'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_drop_count", 32'(count), 32'd4);
    checkOutput("full_head", bus.out_result, 32'd1);

    // Push and pop together while full: only the pop happens
    applyStimulus(1'b1, 32'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("fullpp_count", 32'(count), 32'd3);
    checkOutput("fullpp_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 32'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("refill_count", 32'(count), 32'd4);
    begin
      logic [31:0] drain_exp [4];
      drain_exp = '{32'd2, 32'd3, 32'd4, 32'd9};
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("drain_%0d", i), bus.out_result, drain_exp[i]);
        applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Steady push/pop at occupancy 2, pointers wrap several times
    applyStimulus(1'b1, 32'd100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd101, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("stream_%0d", i), bus.out_result, 32'(100 + i));
      applyStimulus(1'b1, 32'(102 + i), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("stream_count", 32'(count), 32'd2);
    checkOutput("stream_tail0", bus.out_result, 32'd120);
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stream_tail1", bus.out_result, 32'd121);
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stream_empty", 32'(count), 32'd0);
    checkOutput("pre_ovf_sticky", 32'(sticky_ovf), 32'd0);

    // Overflow statistics: first push fills, later ones push+pop at count 1
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(200 + i), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("ovf3_sticky", 32'(sticky_ovf), 32'd1);
    checkOutput("ovf3_cnt", 32'(ovf_cnt), 32'd3);
    checkOutput("ovf3_head_flag", 32'(bus.out_overflow), 32'd1);
    checkOutput("ovf3_head", bus.out_result, 32'd202);
    applyStimulus(1'b1, 32'd210, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("clrpush_sticky", 32'(sticky_ovf), 32'd1);
    checkOutput("clrpush_cnt", 32'(ovf_cnt), 32'd1);
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_sticky", 32'(sticky_ovf), 32'd0);
    checkOutput("clr_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("clr_count", 32'(count), 32'd1);
    checkOutput("clr_head", bus.out_result, 32'd210);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 32'(1000 + i), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("sat_cnt", 32'(ovf_cnt), 32'd255);
    checkOutput("sat_count", 32'(count), 32'd1);

    // Asynchronous reset mid-operation with three entries held
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(50 + i), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("prerst_count", 32'(count), 32'd3);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_sticky", 32'(sticky_ovf), 32'd0);
    checkOutput("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("arst_out_result", bus.out_result, 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_rst_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 32'h0000_ABCD, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_head", bus.out_result, 32'h0000_ABCD);
    checkOutput("post_rst_op", 32'(bus.out_op), 32'd7);
    checkOutput("post_rst_push_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered ALU results (power of two, 2..16).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  producer (ALU stage) offers a result this cycle.
REQ-005 in_ready  output  1  FIFO accepts a result this cycle.
REQ-006 in_result  input  32  ALU result word.
REQ-007 in_zero / in_cout / in_overflow  input  1 each  ALU flags accompanying in_result.
REQ-008 in_op  input  4  ALU_control code that produced the result.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  consumer takes head entry this cycle.
REQ-011 out_result / out_zero / out_cout / out_overflow / out_op  output  32/1/1/1/4  head entry fields.
REQ-012 count  output  log2(DEPTH)+1  number of occupied entries.
REQ-013 sticky_ovf  output  1  set once any accepted result carried overflow.
REQ-014 ovf_cnt  output  8  saturating count of accepted results with overflow.
REQ-015 clr_status  input  1  synchronous clear of sticky_ovf and ovf_cnt.

Function
REQ-016 Push occurs when in_valid and in_ready are both 1 at a rising edge; pop occurs when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (count != DEPTH), registered-state driven, no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0); no input-to-output bypass, so an entry pushed into an empty FIFO appears on out_* exactly one cycle after the push edge.
REQ-019 out_* SHALL present the oldest unpopped entry, fields unchanged from push; out_* are don't-care while out_valid is 0 but SHALL not be X after reset.
REQ-020 Storage is a circular buffer with write and read pointers wrapping from DEPTH-1 to 0.
REQ-021 Count update per edge: push only +1, pop only -1, both or neither unchanged.
REQ-022 Full (count == DEPTH): in_ready 0, in_valid ignored, entries preserved; a pop the same cycle frees one slot, in_ready rises next cycle.
REQ-023 Empty (count == 0): out_ready ignored, no pointer movement.
REQ-024 Simultaneous push and pop at any non-empty, non-full occupancy SHALL keep count constant and preserve order.
REQ-025 sticky_ovf SHALL set on the edge of a push with in_overflow 1 and hold until clr_status or rst.
REQ-026 ovf_cnt SHALL increment on each push with in_overflow 1, saturating at 255.
REQ-027 clr_status and an overflow push on the same edge: clear then count, i.e. sticky_ovf = 1, ovf_cnt = 1.
REQ-028 clr_status SHALL not affect FIFO contents, pointers or count.
REQ-029 Flags carried through the FIFO (zero, cout, overflow) SHALL not be recomputed or altered.

Reset
REQ-030 While rst is 1, independent of clk: pointers 0, count 0, out_valid 0, in_ready 0, sticky_ovf 0, ovf_cnt 0, out_* all 0.
REQ-031 First rising edge after rst falls: in_ready 1; no push accepted on the edge rst deasserts.
REQ-032 rst asserted mid-operation SHALL discard all entries immediately; no partial pop or push completes.

Verification
REQ-033 Push in_result=32'h0000_0005, in_op=4'b0010, flags 0 into empty FIFO, out_ready 0 -> out_valid 1 one cycle later, out_result 5, out_op 2, count 1.
REQ-034 Push 4 results 1,2,3,4 with out_ready 0 -> count 4, in_ready 0; fifth push with value 5 dropped; then drain with out_ready 1 -> outputs 1,2,3,4 in order, count 0, out_valid 0.
REQ-035 Full FIFO, push 9 and pop same cycle -> push not accepted (in_ready 0), count 3, next cycle in_ready 1; push 9 -> appears after 2,3,4.
REQ-036 Continuous push/pop at count 2 for 20 cycles with incrementing data -> count stays 2, output sequence strictly ordered, pointers wrap without loss.
REQ-037 Push 3 results with in_overflow 1, then clr_status together with another overflow push -> sticky_ovf 1, ovf_cnt 3 before, 1 after; 300 overflow pushes -> ovf_cnt 255.
REQ-038 rst pulsed asynchronously between edges with count 3 -> out_valid, count, sticky_ovf drop to 0 immediately; after release, FIFO accepts new data as empty.
